// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, DIFF = A - B - BIN.
// One bit per clock, LSB first. Each bit uses a one-hot minterm cell over
// {a_bit, b_bit, borrow}. A start/busy/done handshake wraps the datapath.
// Optional feature macro: SUB_OVF_EN enables the signed overflow flag (ovf).
// When SUB_OVF_EN is not defined, ovf is tied to 0 and no extra flops exist.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] res_r;
  logic             brw_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       cell_s;
  logic             last_s;

  // One-hot minterm subtract cell. Result is {borrow_out, difference}.
  // Minterm index is {x, y, borrow_in}.
  function automatic logic [1:0] sub_cell(input logic x, input logic y, input logic bi);
    logic [7:0] m;
    m = 8'd1 << {x, y, bi};
    return {m[1] | m[2] | m[3] | m[7], m[1] | m[2] | m[4] | m[7]};
  endfunction

  // Evaluate the current bit cell and detect the final bit position
  always_comb begin
    cell_s = sub_cell(sa_r[0], sb_r[0], brw_r);
    last_s = (cnt_r == LAST_BIT);
  end

  // Next-state logic for IDLE -> RUN -> DONE -> IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_RUN;
        else       state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_nxt_s = ST_DONE;
        else        state_nxt_s = ST_RUN;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register with registered busy/done decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s == ST_RUN);
      done    <= (state_nxt_s == ST_DONE);
    end
  end

  // Operand capture, bit-serial shifting and result publication
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_r  <= '0;
      sb_r  <= '0;
      res_r <= '0;
      brw_r <= 1'b0;
      cnt_r <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            sa_r  <= a;
            sb_r  <= b;
            brw_r <= bin;
            cnt_r <= '0;
          end
        end
        ST_RUN: begin
          res_r <= {cell_s[0], res_r[WIDTH-1:1]};
          sa_r  <= sa_r >> 1;
          sb_r  <= sb_r >> 1;
          brw_r <= cell_s[1];
          cnt_r <= cnt_r + CNT_W'(1);
          // diff/bout keep the previous result until the final bit lands
          if (last_s) begin
            diff <= {cell_s[0], res_r[WIDTH-1:1]};
            bout <= cell_s[1];
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SUB_OVF_EN
  logic a_msb_r;
  logic b_msb_r;

  // Capture operand signs at acceptance; publish overflow with the result
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      ovf     <= 1'b0;
    end else if (state_r == ST_IDLE && start) begin
      a_msb_r <= a[WIDTH-1];
      b_msb_r <= b[WIDTH-1];
    end else if (state_r == ST_RUN && last_s) begin
      // The final difference bit computed this cycle is the result MSB
      ovf <= (a_msb_r != b_msb_r) && (cell_s[0] != a_msb_r);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed test-plan
// cases, randomized operands against an arithmetic reference model, an
// ignored-start case and a mid-operation reset case.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] last_diff;
  logic         last_bout;
  logic         last_ovf;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .ovf  (ovf)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operand values
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                                output logic [W-1:0] md, output logic mbo, output logic mov);
    longint ua, ub, si_a, si_b, sr;
    ua   = longint'(ma);
    ub   = longint'(mb);
    md   = W'(ua - ub - longint'(mbin));
    mbo  = (ua < ub + longint'(mbin));
    si_a = ma[W-1] ? ua - (longint'(1) << W) : ua;
    si_b = mb[W-1] ? ub - (longint'(1) << W) : ub;
    sr   = si_a - si_b - longint'(mbin);
`ifdef SUB_OVF_EN
    mov  = (sr < -(longint'(1) << (W-1))) || (sr > (longint'(1) << (W-1)) - 1);
`else
    mov  = 1'b0;
`endif
  endfunction

  // Full transaction starting in IDLE; ends one cycle after the done pulse
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    model(ta, tb_v, tbin, ed, eb, eo);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    step();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      chk("busy", busy, 32'd1);
      chk("done_low", done, 32'd0);
      chk("diff_hold", diff, last_diff);
      chk("bout_hold", bout, last_bout);
      step();
    end
    chk("busy_end", busy, 32'd0);
    chk("done", done, 32'd1);
    chk("diff", diff, ed);
    chk("bout", bout, eb);
    chk("ovf", ovf, eo);
    step();
    chk("done_pulse", done, 32'd0);
    chk("diff_held", diff, ed);
    last_diff = ed;
    last_bout = eb;
    last_ovf  = eo;
  endtask

  initial begin
    int n_done;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_diff", diff, 32'd0);
    chk("rst_bout", bout, 32'd0);
    chk("rst_ovf", ovf, 32'd0);
    rst = 1'b0;
    last_diff = '0; last_bout = 1'b0; last_ovf = 1'b0;
    step();

    // Directed test-plan operands, back to back at the earliest acceptance
    run_op(8'h35, 8'h12, 1'b0);
    chk("plan_35_12", diff, 32'h23);
    run_op(8'h12, 8'h35, 1'b0);
    chk("plan_12_35", diff, 32'hDD);
    chk("plan_12_35_bout", bout, 32'd1);
    run_op(8'h00, 8'h00, 1'b1);
    chk("plan_00_00_1", diff, 32'hFF);
    run_op(8'hFF, 8'hFF, 1'b0);
    chk("plan_FF_FF", diff, 32'h00);
    run_op(8'h80, 8'h01, 1'b0);
    chk("plan_80_01", diff, 32'h7F);
    run_op(8'h7F, 8'h01, 1'b0);
    chk("plan_7F_01", diff, 32'h7E);

    // Randomized operands
    for (int i = 0; i < 24; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom));
    end

    // Second start two cycles into RUN must be ignored
    a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1; a = 8'hAA; b = 8'h55;
    step();
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (done) n_done++;
      step();
    end
    chk("ignore_done_count", n_done, 32'd1);
    chk("ignore_diff", diff, 32'h23);
    chk("ignore_bout", bout, 32'd0);
    last_diff = 8'h23; last_bout = 1'b0; last_ovf = 1'b0;

    // Reset during the fourth RUN cycle aborts the operation
    a = 8'hC3; b = 8'h5A; bin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy, 32'd0);
    chk("abort_done", done, 32'd0);
    chk("abort_diff", diff, 32'd0);
    chk("abort_bout", bout, 32'd0);
    chk("abort_ovf", ovf, 32'd0);
    n_done = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (done) n_done++;
      step();
    end
    chk("abort_no_done", n_done, 32'd0);
    last_diff = '0; last_bout = 1'b0; last_ovf = 1'b0;
    run_op(8'h35, 8'h12, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
